issue_queue: RTL

//  Reservation-station queue directly downstream of the operand select stage.

---
 rtl/issue_queue.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue
//  Description : Collapsing reservation-station queue. Holds instructions
//                waiting on operands, snoops the writeback bus for missing
//                values and dispatches the oldest fully-ready entry through
//                a registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_queue #(
    parameter int DATA      = 32,
    parameter int ROB_DEPTH = 16,
    parameter int IQ_DEPTH  = 4,
    parameter int OP        = 32,
    parameter int ROB       = $clog2(ROB_DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            flush_,
    input  logic            in_e_,
    input  logic [OP-1:0]   in_op,
    input  logic [ROB-1:0]  in_rob_id,
    input  logic [DATA-1:0] data1,
    input  logic            data1_e_,
    input  logic [DATA-1:0] data2,
    input  logic            data2_e_,
    output logic            iq_busy,
    input  logic            wb_e_,
    input  logic [ROB-1:0]  wb_rob_id,
    input  logic [DATA-1:0] wb_data,
    input  logic            exe_busy,
    output logic            exe_e_,
    output logic [OP-1:0]   exe_op,
    output logic [ROB-1:0]  exe_rob_id,
    output logic [DATA-1:0] exe_data1,
    output logic [DATA-1:0] exe_data2
);

    localparam int c_idx_w = $clog2(IQ_DEPTH);
    localparam int c_cnt_w = c_idx_w + 1;

    // Queue storage; slot 0 is always the oldest entry, valid slots are contiguous
    logic              r_valid [IQ_DEPTH];
    logic [OP-1:0]     r_op    [IQ_DEPTH];
    logic [ROB-1:0]    r_rob   [IQ_DEPTH];
    logic [DATA-1:0]   r_v1    [IQ_DEPTH];
    logic              r_rdy1  [IQ_DEPTH];
    logic [DATA-1:0]   r_v2    [IQ_DEPTH];
    logic              r_rdy2  [IQ_DEPTH];
    logic [c_cnt_w-1:0] r_count;

    // Registered dispatch stage
    logic              r_exe_e_;
    logic [OP-1:0]     r_exe_op;
    logic [ROB-1:0]    r_exe_rob;
    logic [DATA-1:0]   r_exe_d1;
    logic [DATA-1:0]   r_exe_d2;

    // Next-state view of every slot after shift, wakeup and allocation
    logic              w_nxt_valid [IQ_DEPTH];
    logic [OP-1:0]     w_nxt_op    [IQ_DEPTH];
    logic [ROB-1:0]    w_nxt_rob   [IQ_DEPTH];
    logic [DATA-1:0]   w_nxt_v1    [IQ_DEPTH];
    logic              w_nxt_rdy1  [IQ_DEPTH];
    logic [DATA-1:0]   w_nxt_v2    [IQ_DEPTH];
    logic              w_nxt_rdy2  [IQ_DEPTH];

    logic               w_sel_found;
    logic [c_idx_w-1:0] w_sel_idx;
    logic               w_dispatch;
    logic               w_alloc;
    logic               w_wb;
    logic [c_cnt_w-1:0] w_alloc_slot;
    logic [DATA-1:0]    w_new_v1;
    logic               w_new_rdy1;
    logic [DATA-1:0]    w_new_v2;
    logic               w_new_rdy2;

    assign iq_busy    = (r_count == c_cnt_w'(IQ_DEPTH));
    assign w_wb       = ~wb_e_;
    // Flush wins over everything else that cycle, so gate issue and dispatch with it
    assign w_alloc    = ~in_e_ & ~iq_busy & flush_;
    assign w_dispatch = w_sel_found & (r_exe_e_ | ~exe_busy) & flush_;
    // A same-cycle removal shifts the tail down one, so the new entry lands one lower
    assign w_alloc_slot = r_count - c_cnt_w'(w_dispatch);

    assign exe_e_     = r_exe_e_;
    assign exe_op     = r_exe_op;
    assign exe_rob_id = r_exe_rob;
    assign exe_data1  = r_exe_d1;
    assign exe_data2  = r_exe_d2;

    // Pick the lowest-index entry with both operands ready (scan high to low so low wins)
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && r_rdy1[i] && r_rdy2[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_idx_w'(i);
            end
        end
    end

    // Incoming operands also snoop the writeback bus on the cycle they are allocated
    always_comb begin
        w_new_v1   = data1;
        w_new_rdy1 = ~data1_e_;
        w_new_v2   = data2;
        w_new_rdy2 = ~data2_e_;
        if (w_wb && data1_e_ && (data1[ROB-1:0] == wb_rob_id)) begin
            w_new_v1   = wb_data;
            w_new_rdy1 = 1'b1;
        end
        if (w_wb && data2_e_ && (data2[ROB-1:0] == wb_rob_id)) begin
            w_new_v2   = wb_data;
            w_new_rdy2 = 1'b1;
        end
    end

    // Per-slot next state: collapse over the dispatched slot, apply wakeup, then allocate
    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (w_dispatch && (w_sel_idx <= c_idx_w'(i))) begin
                // The top slot has nothing above it to shift in, so it empties
                w_nxt_valid[i] = (i != IQ_DEPTH - 1) && r_valid[(i + 1) % IQ_DEPTH];
                w_nxt_op[i]    = r_op  [(i + 1) % IQ_DEPTH];
                w_nxt_rob[i]   = r_rob [(i + 1) % IQ_DEPTH];
                w_nxt_v1[i]    = r_v1  [(i + 1) % IQ_DEPTH];
                w_nxt_rdy1[i]  = r_rdy1[(i + 1) % IQ_DEPTH];
                w_nxt_v2[i]    = r_v2  [(i + 1) % IQ_DEPTH];
                w_nxt_rdy2[i]  = r_rdy2[(i + 1) % IQ_DEPTH];
            end else begin
                w_nxt_valid[i] = r_valid[i];
                w_nxt_op[i]    = r_op[i];
                w_nxt_rob[i]   = r_rob[i];
                w_nxt_v1[i]    = r_v1[i];
                w_nxt_rdy1[i]  = r_rdy1[i];
                w_nxt_v2[i]    = r_v2[i];
                w_nxt_rdy2[i]  = r_rdy2[i];
            end

            // Only a waiting operand compares its tag; ready values are never overwritten
            if (w_wb && w_nxt_valid[i] && !w_nxt_rdy1[i] &&
                (w_nxt_v1[i][ROB-1:0] == wb_rob_id)) begin
                w_nxt_v1[i]   = wb_data;
                w_nxt_rdy1[i] = 1'b1;
            end
            if (w_wb && w_nxt_valid[i] && !w_nxt_rdy2[i] &&
                (w_nxt_v2[i][ROB-1:0] == wb_rob_id)) begin
                w_nxt_v2[i]   = wb_data;
                w_nxt_rdy2[i] = 1'b1;
            end

            if (w_alloc && (w_alloc_slot == c_cnt_w'(i))) begin
                w_nxt_valid[i] = 1'b1;
                w_nxt_op[i]    = in_op;
                w_nxt_rob[i]   = in_rob_id;
                w_nxt_v1[i]    = w_new_v1;
                w_nxt_rdy1[i]  = w_new_rdy1;
                w_nxt_v2[i]    = w_new_v2;
                w_nxt_rdy2[i]  = w_new_rdy2;
            end
        end
    end

    // Queue storage and occupancy count
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_count <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_op[i]    <= '0;
                r_rob[i]   <= '0;
                r_v1[i]    <= '0;
                r_rdy1[i]  <= 1'b0;
                r_v2[i]    <= '0;
                r_rdy2[i]  <= 1'b0;
            end
        end else if (!flush_) begin
            r_count <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else begin
            r_count <= r_count + c_cnt_w'(w_alloc) - c_cnt_w'(w_dispatch);
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_valid[i] <= w_nxt_valid[i];
                r_op[i]    <= w_nxt_op[i];
                r_rob[i]   <= w_nxt_rob[i];
                r_v1[i]    <= w_nxt_v1[i];
                r_rdy1[i]  <= w_nxt_rdy1[i];
                r_v2[i]    <= w_nxt_v2[i];
                r_rdy2[i]  <= w_nxt_rdy2[i];
            end
        end
    end

    // Output stage: load on dispatch, drain when the consumer is free, hold while it stalls
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_exe_e_  <= 1'b1;
            r_exe_op  <= '0;
            r_exe_rob <= '0;
            r_exe_d1  <= '0;
            r_exe_d2  <= '0;
        end else if (!flush_) begin
            r_exe_e_  <= 1'b1;
        end else if (w_dispatch) begin
            r_exe_e_  <= 1'b0;
            r_exe_op  <= r_op[w_sel_idx];
            r_exe_rob <= r_rob[w_sel_idx];
            r_exe_d1  <= r_v1[w_sel_idx];
            r_exe_d2  <= r_v2[w_sel_idx];
        end else if (!exe_busy) begin
            r_exe_e_  <= 1'b1;
        end
    end

endmodule
`default_nettype wire
